cacc_dlv_credit_sched: RTL

//  Sequences CACC delivery: tracks assembly-buffer entries completed by MAC stripes and issues read slots to the SDP-side drain.

---
 rtl/cacc_dlv_pkg.sv | 17 +
 rtl/cacc_dlv_credit_acc.sv | 46 ++++
 rtl/cacc_dlv_credit_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cacc_dlv_pkg.sv
// Shared types and constants for the CACC delivery credit scheduler.
// Optional stall counter enabled by defining CACC_DLV_PERF_EN.
package cacc_dlv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned CREDIT_GRAN = 4;
  localparam int unsigned CREDIT_MAX  = 7;

  typedef logic [2:0] credit_size_t;

endpackage

// File: rtl/cacc_dlv_credit_acc.sv
// Pending-credit accumulator: counts consumed slots and emits
// registered credit pulses of up to CREDIT_MAX entries.
module cacc_dlv_credit_acc
  import cacc_dlv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hs,
  input  logic         flush,
  output logic         pend_zero,
  output logic         credit_vld,
  output credit_size_t credit_size
);

  logic [3:0]   pend_q, pend_d;
  logic         vld_q, vld_d;
  credit_size_t size_q, size_d;
  logic [3:0]   issued;
  logic         fire;

  always_comb begin
    issued = (pend_q > 4'(CREDIT_MAX)) ? 4'(CREDIT_MAX) : pend_q;
    fire   = (pend_q >= 4'(CREDIT_GRAN)) | (flush & (pend_q != 4'd0));
    // same-cycle hs stays pending; only the issued amount leaves
    pend_d = pend_q + {3'b000, hs} - (fire ? issued : 4'd0);
    vld_d  = fire;
    size_d = fire ? issued[2:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      vld_q  <= 1'b0;
      size_q <= '0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      size_q <= size_d;
    end
  end

  assign pend_zero   = (pend_q == 4'd0);
  assign credit_vld  = vld_q;
  assign credit_size = size_q;

endmodule

// File: rtl/cacc_dlv_credit_sched.sv
// CACC delivery sequencer: occupancy tracking, read slots, credits, done irq.
// Define CACC_DLV_PERF_EN to build the dlv_valid & !dlv_ready stall counter.
module cacc_dlv_credit_sched
  import cacc_dlv_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int OW   = AW + 1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          cfg_op_en,
  input  logic          mac_stripe_end_vld,
  input  logic [6:0]    mac_stripe_entries,
  input  logic          mac_layer_end,
  output logic          dlv_valid,
  input  logic          dlv_ready,
  output logic [AW-1:0] dlv_rd_addr,
  output logic          dlv_last,
  output logic          accu2sc_credit_vld,
  output logic [2:0]    accu2sc_credit_size,
  output logic [1:0]    cacc2glb_done_intr_pd,
  output logic          dlv_busy,
  output logic          err_ovf,
  output logic [31:0]   perf_stall_cnt
);

  state_e        state_q, state_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          group_q, group_d;
  logic          err_q, err_d;
  logic          active, accept, hs, flush, pend_zero;
  logic [7:0]    sum;

  assign active = (state_q == RUN) | (state_q == DRAIN);
  assign accept = active & mac_stripe_end_vld;
  assign hs     = dlv_valid & dlv_ready;
  assign flush  = (state_q == DRAIN) & (occ_q == '0);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q  <= IDLE;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      group_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      group_q  <= group_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cfg_op_en) state_d = RUN;
      RUN:   if (mac_stripe_end_vld & mac_layer_end) state_d = DRAIN;
      DRAIN: if ((occ_q == '0) & pend_zero) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum = {{(8-OW){1'b0}}, occ_q}
        + (accept ? {1'b0, mac_stripe_entries} : 8'd0)
        - {7'd0, hs};
    occ_d    = occ_q;
    err_d    = err_q;
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, hs};
    group_d  = group_q ^ (state_q == DONE);
    if (sum > 8'(DEPTH)) begin
      occ_d = OW'(DEPTH);
      err_d = 1'b1;
    end else begin
      occ_d = sum[OW-1:0];
    end
  end

  always_comb begin
    dlv_valid             = active & (occ_q != '0);
    dlv_last              = (state_q == DRAIN) & (occ_q == OW'(1));
    dlv_rd_addr           = rd_ptr_q;
    dlv_busy              = (state_q != IDLE);
    err_ovf               = err_q;
    cacc2glb_done_intr_pd = 2'b00;
    if (state_q == DONE)
      cacc2glb_done_intr_pd = group_q ? 2'b10 : 2'b01;
  end

  cacc_dlv_credit_acc u_credit (
    .clk         (nvdla_core_clk),
    .rst         (nvdla_core_rst),
    .hs          (hs),
    .flush       (flush),
    .pend_zero   (pend_zero),
    .credit_vld  (accu2sc_credit_vld),
    .credit_size (accu2sc_credit_size)
  );

`ifdef CACC_DLV_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) & cfg_op_en)
      stall_d = '0;
    else if (dlv_valid & ~dlv_ready & (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) stall_q <= '0;
    else                stall_q <= stall_d;
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
